// File: rtl/reg_alu_seq.sv
// Multi-cycle register-to-register command sequencer between a 2R/1W register
// file and an external ALU, with a Start/Busy/Done handshake.
module reg_alu_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_imm,
  output logic [ADDR_W-1:0] o_r_addr_c,
  output logic [ADDR_W-1:0] o_r_addr_b,
  input  logic [DATA_W-1:0] i_r_data_c,
  input  logic [DATA_W-1:0] i_r_data_b,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [DATA_W-1:0] o_w_data,
  output logic              o_write_reg,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [2:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_f,
  input  logic              i_alu_zf,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zf
);

  localparam logic [1:0] CMD_ALU   = 2'b00;
  localparam logic [1:0] CMD_LOADI = 2'b01;
  localparam logic [1:0] CMD_MOVE  = 2'b10;
  localparam logic [1:0] CMD_RSV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_rd_nxt;
  logic [1:0]          r_cmd;
  logic [ADDR_W-1:0]   r_rs;
  logic [ADDR_W-1:0]   r_rt;
  logic [ADDR_W-1:0]   r_rd;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [2:0]          r_alu_op;
  logic [DATA_W-1:0]   r_result;
  logic                r_zf;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic                r_write_reg;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_rd_nxt = w_accept ? i_rd : r_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          case (i_cmd)
            CMD_LOADI: w_state_nxt = S_WB;
            CMD_RSV:   w_state_nxt = S_DONE;
            default:   w_state_nxt = S_RD;
          endcase
        end
      end
      S_RD:    w_state_nxt = (r_cmd == CMD_ALU) ? S_EX : S_WB;
      S_EX:    w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latches, operand capture and result tracking
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_op        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_result    <= '0;
      r_zf        <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_write_reg <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      // r0 is hard-wired zero, so a write to it is suppressed
      r_write_reg <= (w_state_nxt == S_WB) && (w_rd_nxt != '0);
      if (w_accept) begin
        r_cmd <= i_cmd;
        r_rs  <= i_rs;
        r_rt  <= i_rt;
        r_rd  <= i_rd;
        r_op  <= i_op;
        r_err <= (i_cmd == CMD_RSV);
        if (i_cmd == CMD_LOADI) r_result <= i_imm;
      end
      if (r_state == S_RD) begin
        // Operands are only presented to the ALU for ALU commands
        if (r_cmd == CMD_ALU) begin
          r_alu_a  <= i_r_data_c;
          r_alu_b  <= i_r_data_b;
          r_alu_op <= r_op;
        end else if (r_cmd == CMD_MOVE) begin
          r_result <= i_r_data_c;
        end
      end
      if (r_state == S_EX) begin
        r_result <= i_alu_f;
        r_zf     <= i_alu_zf;
      end
    end
  end

  assign o_r_addr_c  = r_rs;
  assign o_r_addr_b  = r_rt;
  assign o_w_addr    = r_rd;
  assign o_w_data    = r_result;
  assign o_write_reg = r_write_reg;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_result    = r_result;
  assign o_zf        = r_zf;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Bench for reg_alu_seq: behavioural register file and ALU around the DUT,
// directed vector table, hand sequences and randomized commands vs a model.
module tb_reg_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cmd;
  logic [4:0]  rs, rt, rd;
  logic [2:0]  op;
  logic [31:0] imm;
  logic [4:0]  r_addr_c, r_addr_b, w_addr;
  logic [31:0] r_data_c, r_data_b, w_data;
  logic        write_reg;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [2:0]  alu_op;
  logic        alu_zf;
  logic        busy, done, err, zf;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_alu_seq #(.DATA_W(32), .ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd(cmd),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_op(op), .i_imm(imm),
    .o_r_addr_c(r_addr_c), .o_r_addr_b(r_addr_b),
    .i_r_data_c(r_data_c), .i_r_data_b(r_data_b),
    .o_w_addr(w_addr), .o_w_data(w_data), .o_write_reg(write_reg),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_f(alu_f), .i_alu_zf(alu_zf),
    .o_busy(busy), .o_done(done), .o_err(err), .o_result(result), .o_zf(zf)
  );

  // Register file written by the DUT
  logic [31:0] rf [32] = '{default: 32'd0};
  assign r_data_c = (r_addr_c == 5'd0) ? 32'd0 : rf[r_addr_c];
  assign r_data_b = (r_addr_b == 5'd0) ? 32'd0 : rf[r_addr_b];
  always @(posedge clk) if (write_reg && w_addr != 5'd0) rf[w_addr] <= w_data;

  function automatic logic [31:0] alu_fn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a < b) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return ~(a | b);
    endcase
  endfunction

  assign alu_f  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zf = (alu_f == 32'd0);

  typedef struct {
    logic [1:0]  cmd;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  op;
    logic [31:0] imm;
    int          lat;
    logic        wr;
    logic [31:0] res;
    logic        zf;
    logic        err;
    logic [31:0] a, b;
  } vec_t;

  // Reference model state
  logic [31:0] mreg [32] = '{default: 32'd0};
  logic [31:0] mres = 32'd0;
  logic        mzf  = 1'b0;
  logic        merr = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [2:0] o, input logic [31:0] im,
                              input int lat, input logic wr, input logic [31:0] res,
                              input logic z, input logic e, input logic [31:0] a,
                              input logic [31:0] b);
    vec_t v;
    v.cmd = c; v.rs = s; v.rt = t; v.rd = d; v.op = o; v.imm = im;
    v.lat = lat; v.wr = wr; v.res = res; v.zf = z; v.err = e; v.a = a; v.b = b;
    return v;
  endfunction

  // Advance the model by one command and fill in its expectations
  task automatic model_step(inout vec_t v);
    logic [31:0] a, b;
    a = mreg[v.rs];
    b = mreg[v.rt];
    v.a = a;
    v.b = b;
    case (v.cmd)
      2'd0: begin mres = alu_fn(v.op, a, b); mzf = (mres == 32'd0); merr = 1'b0; v.lat = 4; end
      2'd1: begin mres = v.imm; merr = 1'b0; v.lat = 2; end
      2'd2: begin mres = a; merr = 1'b0; v.lat = 3; end
      default: begin merr = 1'b1; v.lat = 1; end
    endcase
    v.wr = (v.cmd != 2'd3) && (v.rd != 5'd0);
    if (v.wr) mreg[v.rd] = mres;
    v.res = mres;
    v.zf  = mzf;
    v.err = merr;
  endtask

  task automatic run(input vec_t v);
    int lat, nwr;
    logic [4:0]  wa;
    logic [31:0] wd;
    lat = 0; nwr = 0; wa = '0; wd = '0;
    @(negedge clk);
    start = 1'b1; cmd = v.cmd; rs = v.rs; rt = v.rt; rd = v.rd; op = v.op; imm = v.imm;
    @(posedge clk); #1;
    // Fields changing after acceptance must not matter
    start = 1'b0; cmd = 2'($urandom); rs = 5'($urandom); rt = 5'($urandom);
    rd = 5'($urandom); op = 3'($urandom); imm = $urandom;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2 && v.cmd == 2'd0) begin
        check("alu_a", alu_a, v.a);
        check("alu_b", alu_b, v.b);
        check("alu_op", 32'(alu_op), 32'(v.op));
      end
      if (write_reg) begin nwr++; wa = w_addr; wd = w_data; end
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    check("latency", 32'(lat), 32'(v.lat));
    check("writes", 32'(nwr), v.wr ? 32'd1 : 32'd0);
    if (v.wr) begin
      check("w_addr", 32'(wa), 32'(v.rd));
      check("w_data", wd, v.res);
    end
    check("result", result, v.res);
    check("zf", 32'(zf), 32'(v.zf));
    check("err", 32'(err), 32'(v.err));
    check("regfile", rf[v.rd], mreg[v.rd]);
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  vec_t dir [8];
  vec_t v;
  int   nwr, ndone;

  initial begin
    start = 1'b0; cmd = '0; rs = '0; rt = '0; rd = '0; op = '0; imm = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_rel", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr", 32'(write_reg), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    //             cmd   rs  rt  rd  op  imm           lat wr res           zf  err a      b
    dir[0] = mk(2'd1, 0, 0, 1, 0, 32'h0000_0005, 2, 1, 32'h0000_0005, 0, 0, 0, 0);
    dir[1] = mk(2'd1, 0, 0, 2, 0, 32'h0000_0003, 2, 1, 32'h0000_0003, 0, 0, 0, 0);
    dir[2] = mk(2'd0, 1, 2, 3, 0, 32'h0,         4, 1, 32'h0000_0008, 0, 0, 5, 3);
    dir[3] = mk(2'd0, 1, 1, 1, 1, 32'h0,         4, 1, 32'h0000_0000, 1, 0, 5, 5);
    dir[4] = mk(2'd2, 3, 0, 4, 0, 32'h0,         3, 1, 32'h0000_0008, 1, 0, 0, 0);
    dir[5] = mk(2'd1, 0, 0, 0, 0, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    dir[6] = mk(2'd3, 0, 0, 6, 0, 32'h0,         1, 0, 32'hFFFF_FFFF, 1, 1, 0, 0);
    dir[7] = mk(2'd1, 0, 0, 5, 0, 32'h0000_0007, 2, 1, 32'h0000_0007, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      v = dir[i];
      model_step(v);
      run(dir[i]);
    end

    // Start held high through an ALU command: r3 <= r3 + r4 must happen once
    v = mk(2'd0, 3, 4, 3, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    model_step(v);
    nwr = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1; cmd = v.cmd; rs = v.rs; rt = v.rt; rd = v.rd; op = v.op; imm = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin
      if (write_reg) nwr++;
      if (done) ndone++;
      if (c < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_writes", 32'(nwr), 32'd1);
    check("hold_dones", 32'(ndone), 32'd1);
    check("hold_result", result, v.res);
    check("hold_rf", rf[3], mreg[3]);

    // Reset asserted while in EX aborts the command
    @(negedge clk);
    start = 1'b1; cmd = 2'd0; rs = 5'd1; rt = 5'd3; rd = 5'd7; op = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_waddr", 32'(w_addr), 32'd0);
    check("abort_raddr", 32'(r_addr_c), 32'd0);
    nwr = 0; ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (write_reg) nwr++;
      if (done) ndone++;
    end
    check("abort_writes", 32'(nwr), 32'd0);
    check("abort_dones", 32'(ndone), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mres = 32'd0; mzf = 1'b0; merr = 1'b0;
    @(posedge clk); #1;
    check("abort_rf7", rf[7], mreg[7]);
    check("abort_zf", 32'(zf), 32'd0);

    // Randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      v = mk((sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3,
             5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), $urandom,
             0, 0, 0, 0, 0, 0, 0);
      model_step(v);
      run(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
